// File: rtl/fifo_pkt_framer_if.sv
// Upstream byte stream and async-FIFO write port of the packet framer.
// master drives payload and the FIFO full flag; slave is the framer.
interface fifo_pkt_framer_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  s_valid;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_last;
    logic                  s_ready;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  fifo_wr_en;
    logic                  fifo_full;

    modport master (
        output s_valid, s_data, s_last, fifo_full,
        input  s_ready, fifo_data, fifo_wr_en
    );

    modport slave (
        input  s_valid, s_data, s_last, fifo_full,
        output s_ready, fifo_data, fifo_wr_en
    );
endinterface

// File: rtl/fifo_pkt_framer.sv
// Buffers an upstream packet, then writes SOF, LEN, payload, CSUM into an async FIFO.
// Packets longer than MAX_LEN are framed truncated and the remainder is dropped.
//
// state     | meaning
// IDLE      | waiting for first payload byte
// COLLECT   | storing payload bytes, accumulating checksum
// SEND_SOF  | writing start-of-frame marker
// SEND_LEN  | writing payload length
// SEND_PAY  | writing buffered payload, index rd_idx
// SEND_CSUM | writing checksum (LEN xor payload)
// DROP      | discarding the overflow tail of a truncated packet
module fifo_pkt_framer #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    MAX_LEN    = 16,
    parameter logic [DATA_WIDTH-1:0] SOF_BYTE   = 8'hA5
) (
    input  logic                clka,
    input  logic                rstb,
    fifo_pkt_framer_if.slave    bus,
    output logic                pkt_done,
    output logic                err_trunc,
    output logic                busy
);
    localparam int CW = $clog2(MAX_LEN + 1);
    localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    typedef enum logic [2:0] {
        IDLE, COLLECT, SEND_SOF, SEND_LEN, SEND_PAY, SEND_CSUM, DROP
    } state_t;

    state_t                state;
    logic [CW-1:0]         count;
    logic [CW-1:0]         rd_idx;
    logic [DATA_WIDTH-1:0] csum_acc;
    logic                  drop_pending;
    logic [DATA_WIDTH-1:0] pay_mem [MAX_LEN];

    logic          in_send;
    logic          hs;
    logic          wr;
    logic [CW-1:0] count_inc;

    assign in_send   = state inside {SEND_SOF, SEND_LEN, SEND_PAY, SEND_CSUM};
    assign hs        = bus.s_valid & bus.s_ready;
    // Gated by rstb so a frame in flight stops writing the moment reset is applied.
    assign wr        = in_send & ~bus.fifo_full & ~rstb;
    assign count_inc = count + CW'(1);

    assign bus.s_ready    = state inside {IDLE, COLLECT, DROP};
    assign bus.fifo_wr_en = wr;
    assign pkt_done       = wr & (state == SEND_CSUM);
    assign busy           = (state != IDLE) & ~rstb;

    always_comb begin
        bus.fifo_data = '0;
        if (!rstb) begin
            case (state)
                SEND_SOF:  bus.fifo_data = SOF_BYTE;
                SEND_LEN:  bus.fifo_data = DATA_WIDTH'(count);
                SEND_PAY:  bus.fifo_data = pay_mem[rd_idx[IW-1:0]];
                SEND_CSUM: bus.fifo_data = csum_acc ^ DATA_WIDTH'(count);
                default:   bus.fifo_data = '0;
            endcase
        end
    end

    // Payload storage needs no reset; stale bytes are never read back.
    always_ff @(posedge clka) begin
        if (hs && state == IDLE)
            pay_mem[0] <= bus.s_data;
        else if (hs && state == COLLECT)
            pay_mem[count[IW-1:0]] <= bus.s_data;
    end

    always_ff @(posedge clka) begin
        if (rstb) begin
            state        <= IDLE;
            count        <= '0;
            rd_idx       <= '0;
            csum_acc     <= '0;
            drop_pending <= 1'b0;
            err_trunc    <= 1'b0;
        end else begin
            err_trunc <= 1'b0;
            case (state)
                IDLE: begin
                    if (hs) begin
                        count    <= CW'(1);
                        csum_acc <= bus.s_data;
                        state    <= bus.s_last ? SEND_SOF : COLLECT;
                    end
                end
                COLLECT: begin
                    if (hs) begin
                        count    <= count_inc;
                        csum_acc <= csum_acc ^ bus.s_data;
                        if (bus.s_last) begin
                            state <= SEND_SOF;
                        end else if (count_inc == CW'(MAX_LEN)) begin
                            state        <= SEND_SOF;
                            err_trunc    <= 1'b1;
                            drop_pending <= 1'b1;
                        end
                    end
                end
                SEND_SOF: if (wr) state <= SEND_LEN;
                SEND_LEN: if (wr) state <= SEND_PAY;
                SEND_PAY: begin
                    if (wr) begin
                        if (rd_idx == count - CW'(1)) begin
                            rd_idx <= '0;
                            state  <= SEND_CSUM;
                        end else begin
                            rd_idx <= rd_idx + CW'(1);
                        end
                    end
                end
                SEND_CSUM: begin
                    if (wr) begin
                        count    <= '0;
                        csum_acc <= '0;
                        state    <= drop_pending ? DROP : IDLE;
                    end
                end
                DROP: begin
                    if (hs && bus.s_last) begin
                        drop_pending <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_pkt_framer.sv
// Self-checking bench for fifo_pkt_framer: directed scenarios plus randomized
// packets compared against a frame-level reference model.
module tb_fifo_pkt_framer;
    localparam int MAX_LEN = 16;
    typedef logic [7:0] bq_t[$];

    logic clka = 1'b0;
    logic rstb;
    logic pkt_done, err_trunc, busy;
    always #5 clka = ~clka;

    fifo_pkt_framer_if #(.DATA_WIDTH(8)) bus ();

    fifo_pkt_framer #(.DATA_WIDTH(8), .MAX_LEN(MAX_LEN), .SOF_BYTE(8'hA5)) dut (
        .clka(clka), .rstb(rstb), .bus(bus),
        .pkt_done(pkt_done), .err_trunc(err_trunc), .busy(busy)
    );

    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    bit  full_mode = 0;
    int  hs_cyc;
    int  hs_log[$];
    bq_t got_q, exp_q;
    int  got_cyc[$], pkt_cyc[$], trunc_cyc[$];
    int  exp_pkts, exp_trunc;

    always @(posedge clka) cyc <= cyc + 1;

    always @(negedge clka) begin
        if (bus.fifo_wr_en === 1'b1) begin
            got_q.push_back(bus.fifo_data);
            got_cyc.push_back(cyc);
        end
        if (pkt_done === 1'b1) pkt_cyc.push_back(cyc);
        if (err_trunc === 1'b1) trunc_cyc.push_back(cyc);
    end

    // Reference: a frame is SOF, LEN, first min(n,MAX_LEN) bytes, LEN xor payload.
    function automatic void model_pkt(input bq_t pay);
        int len;
        logic [7:0] cs;
        len = (pay.size() > MAX_LEN) ? MAX_LEN : pay.size();
        cs = 8'(len);
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'(len));
        for (int i = 0; i < len; i++) begin
            exp_q.push_back(pay[i]);
            cs = cs ^ pay[i];
        end
        exp_q.push_back(cs);
        exp_pkts++;
        if (pay.size() > MAX_LEN) exp_trunc++;
    endfunction

    task automatic clear_logs();
        got_q.delete(); exp_q.delete(); got_cyc.delete();
        pkt_cyc.delete(); trunc_cyc.delete(); hs_log.delete();
        exp_pkts = 0; exp_trunc = 0;
    endtask

    task automatic tick();
        @(posedge clka); #1;
        if (full_mode) bus.fifo_full = ($urandom_range(0, 3) == 0);
    endtask

    task automatic idle_in();
        bus.s_valid = 1'b0; bus.s_last = 1'b0; bus.s_data = 8'h00;
    endtask

    task automatic push_byte(input logic [7:0] d, input bit last);
        bus.s_valid = 1'b1; bus.s_data = d; bus.s_last = last;
        for (int i = 0; i < 400; i++) begin
            @(negedge clka); #1;
            if (bus.s_ready === 1'b1) begin
                hs_cyc = cyc;
                hs_log.push_back(cyc);
                tick();
                return;
            end
            tick();
        end
        checks++; errors++;
        $display("FAIL push_timeout byte=%0h s_ready never 1", d);
    endtask

    task automatic send_pkt(input bq_t pay, input bit gaps);
        for (int i = 0; i < pay.size(); i++) begin
            push_byte(pay[i], i == pay.size() - 1);
            if (gaps && $urandom_range(0, 1) == 1) begin
                idle_in();
                repeat ($urandom_range(1, 3)) tick();
            end
        end
        idle_in();
    endtask

    task automatic drain();
        int n;
        for (n = 0; n < 2000; n++) begin
            if (busy !== 1'b1) break;
            tick();
        end
        checks++;
        if (n == 2000) begin errors++; $display("FAIL drain_timeout busy stuck at 1"); end
        repeat (2) tick();
    endtask

    task automatic test_reset();
        rstb = 1'b1;
        repeat (3) tick();
        @(negedge clka);
        checks++; if (bus.fifo_wr_en !== 1'b0) begin errors++; $display("FAIL rst_wr_en got=%b exp=0", bus.fifo_wr_en); end
        checks++; if (bus.fifo_data !== 8'h00) begin errors++; $display("FAIL rst_data got=%0h exp=0", bus.fifo_data); end
        checks++; if (pkt_done !== 1'b0) begin errors++; $display("FAIL rst_pkt_done got=%b exp=0", pkt_done); end
        checks++; if (err_trunc !== 1'b0) begin errors++; $display("FAIL rst_err_trunc got=%b exp=0", err_trunc); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
        tick();
        rstb = 1'b0;
        @(negedge clka);
        checks++; if (bus.s_ready !== 1'b1) begin errors++; $display("FAIL rst_s_ready got=%b exp=1", bus.s_ready); end
        tick();
    endtask

    task automatic test_single();
        int hs;
        clear_logs();
        model_pkt('{8'h3C});
        send_pkt('{8'h3C}, 0);
        hs = hs_cyc;
        drain();
        checks++; if (got_q.size() != 4) begin errors++; $display("FAIL single_len got=%0d exp=4", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < 4; i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL single_byte%0d got=%0h exp=%0h", i, got_q[i], exp_q[i]); end
            checks++; if (got_cyc[i] != hs + 1 + i) begin errors++; $display("FAIL single_cyc%0d got=%0d exp=%0d", i, got_cyc[i], hs + 1 + i); end
        end
        checks++;
        if (pkt_cyc.size() != 1 || got_cyc.size() != 4 || pkt_cyc[0] != hs + 4) begin
            errors++; $display("FAIL single_pkt_done pulses=%0d exp=1 at cycle %0d", pkt_cyc.size(), hs + 4);
        end
    endtask

    task automatic test_three();
        int low, n;
        clear_logs();
        model_pkt('{8'h11, 8'h22, 8'h33});
        send_pkt('{8'h11, 8'h22, 8'h33}, 0);
        low = 0;
        for (n = 0; n < 100 && busy === 1'b1; n++) begin
            if (bus.s_ready !== 1'b1) low++;
            tick();
        end
        drain();
        checks++; if (low != 6) begin errors++; $display("FAIL three_ready_low got=%0d exp=6", low); end
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL three_len got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL three_byte%0d got=%0h exp=%0h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_stall();
        int n;
        clear_logs();
        model_pkt('{8'h01, 8'h02});
        send_pkt('{8'h01, 8'h02}, 0);
        for (n = 0; n < 50; n++) begin
            if (got_q.size() >= 3) break;
            tick();
        end
        bus.fifo_full = 1'b1;
        repeat (3) begin
            @(negedge clka);
            checks++; if (bus.fifo_wr_en !== 1'b0) begin errors++; $display("FAIL stall_wr_en got=%b exp=0", bus.fifo_wr_en); end
            tick();
        end
        bus.fifo_full = 1'b0;
        drain();
        checks++; if (got_q.size() != 5) begin errors++; $display("FAIL stall_len got=%0d exp=5", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < 5; i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL stall_byte%0d got=%0h exp=%0h", i, got_q[i], exp_q[i]); end
        end
        for (int i = 1; i < got_cyc.size() && i < 5; i++) begin
            checks++;
            if (got_cyc[i] - got_cyc[i-1] != ((i == 3) ? 4 : 1)) begin
                errors++; $display("FAIL stall_gap%0d got=%0d exp=%0d", i, got_cyc[i] - got_cyc[i-1], (i == 3) ? 4 : 1);
            end
        end
    endtask

    task automatic test_trunc();
        bq_t pay;
        clear_logs();
        for (int i = 0; i < 20; i++) pay.push_back(8'(i));
        model_pkt(pay);
        model_pkt('{8'h7E});
        for (int i = 0; i < 20; i++) push_byte(pay[i], i == 19);
        push_byte(8'h7E, 1);
        idle_in();
        drain();
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL trunc_len got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL trunc_byte%0d got=%0h exp=%0h", i, got_q[i], exp_q[i]); end
        end
        checks++;
        if (trunc_cyc.size() != 1 || hs_log.size() < 16 || trunc_cyc[0] != hs_log[15] + 1) begin
            errors++; $display("FAIL trunc_pulse count=%0d exp=1 one cycle after 16th byte", trunc_cyc.size());
        end
        checks++; if (pkt_cyc.size() != 2) begin errors++; $display("FAIL trunc_pkts got=%0d exp=2", pkt_cyc.size()); end
    endtask

    task automatic test_reset_mid();
        int n;
        clear_logs();
        send_pkt('{8'hD1, 8'hD2, 8'hD3, 8'hD4}, 0);
        for (n = 0; n < 50; n++) begin
            if (got_q.size() >= 1) break;
            tick();
        end
        rstb = 1'b1;
        @(negedge clka);
        checks++; if (bus.fifo_wr_en !== 1'b0) begin errors++; $display("FAIL rmid_wr_en got=%b exp=0", bus.fifo_wr_en); end
        tick();
        rstb = 1'b0;
        repeat (10) tick();
        checks++; if (got_q.size() != 1) begin errors++; $display("FAIL rmid_writes got=%0d exp=1", got_q.size()); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got=%b exp=0", busy); end
        clear_logs();
        model_pkt('{8'h55});
        send_pkt('{8'h55}, 0);
        drain();
        checks++; if (got_q.size() != 4) begin errors++; $display("FAIL rmid_len got=%0d exp=4", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < 4; i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rmid_byte%0d got=%0h exp=%0h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_back_to_back();
        clear_logs();
        model_pkt('{8'hC1, 8'hC2, 8'hC3});
        model_pkt('{8'hE1, 8'hE2});
        push_byte(8'hC1, 0); push_byte(8'hC2, 0); push_byte(8'hC3, 1);
        push_byte(8'hE1, 0); push_byte(8'hE2, 1);
        idle_in();
        drain();
        checks++;
        if (pkt_cyc.size() < 1 || hs_log.size() != 5 || hs_log[3] != pkt_cyc[0] + 1) begin
            errors++; $display("FAIL b2b_restart second packet not accepted cycle after first CSUM");
        end
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL b2b_len got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_byte%0d got=%0h exp=%0h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_random();
        bq_t pay;
        clear_logs();
        full_mode = 1;
        for (int p = 0; p < 30; p++) begin
            pay.delete();
            for (int i = 0; i < $urandom_range(1, 20); i++) pay.push_back(8'($urandom));
            model_pkt(pay);
            send_pkt(pay, $urandom_range(0, 1) == 1);
        end
        drain();
        full_mode = 0;
        bus.fifo_full = 1'b0;
        repeat (2) tick();
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_len got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_byte%0d got=%0h exp=%0h", i, got_q[i], exp_q[i]); end
        end
        checks++; if (pkt_cyc.size() != exp_pkts) begin errors++; $display("FAIL rand_pkts got=%0d exp=%0d", pkt_cyc.size(), exp_pkts); end
        checks++; if (trunc_cyc.size() != exp_trunc) begin errors++; $display("FAIL rand_trunc got=%0d exp=%0d", trunc_cyc.size(), exp_trunc); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rstb = 1'b1;
        bus.fifo_full = 1'b0;
        idle_in();
        test_reset();
        test_single();
        test_three();
        test_stall();
        test_trunc();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fifo_pkt_framer.md
FIFO_PKT_FRAMER -- requirements
Module: fifo_pkt_framer

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, byte width of stream and FIFO data.
REQ-002 The block SHALL have parameter MAX_LEN, default 16, maximum payload bytes per frame (legal 2..255).
REQ-003 The block SHALL have parameter SOF_BYTE, default 8'hA5, start-of-frame marker.
REQ-004 clka  input  1  write-domain clock; all state updates on rising edge.
REQ-005 rstb  input  1  reset, synchronous, active-high.
REQ-006 s_valid  input  1  upstream payload byte valid.
REQ-007 s_data  input  DATA_WIDTH  upstream payload byte.
REQ-008 s_last  input  1  marks final payload byte of a packet.
REQ-009 s_ready  output  1  block accepts upstream byte this cycle.
REQ-010 fifo_data  output  DATA_WIDTH  frame byte to async FIFO data_in.
REQ-011 fifo_wr_en  output  1  FIFO write strobe, to async FIFO wr_en.
REQ-012 fifo_full  input  1  FIFO full flag from async FIFO.
REQ-013 pkt_done  output  1  one-cycle pulse when the checksum byte is written.
REQ-014 err_trunc  output  1  one-cycle pulse when a packet exceeds MAX_LEN.
REQ-015 busy  output  1  high in any state other than IDLE.

Function
REQ-016 Frame format SHALL be: SOF_BYTE, LEN, LEN payload bytes in arrival order, CSUM; LEN = payload count (1..MAX_LEN); CSUM = XOR of LEN and all payload bytes.
REQ-017 States SHALL be IDLE, COLLECT, SEND_SOF, SEND_LEN, SEND_PAY, SEND_CSUM, DROP.
REQ-018 Upstream handshake SHALL occur on a rising edge with s_valid=1 and s_ready=1; s_ready SHALL be 1 exactly in IDLE, COLLECT and DROP.
REQ-019 Payload SHALL be stored in an internal MAX_LEN-entry buffer; the byte counter SHALL be $clog2(MAX_LEN+1) bits wide and never wrap.
REQ-020 IDLE: on handshake, store byte at index 0, count=1; go SEND_SOF if s_last, else COLLECT.
REQ-021 COLLECT: on handshake, store at index count, count+1; go SEND_SOF if s_last or count+1==MAX_LEN.
REQ-022 If count+1==MAX_LEN with s_last=0, err_trunc SHALL pulse on the following cycle and drop_pending SHALL be set.
REQ-023 fifo_wr_en SHALL equal (state in SEND_*) AND NOT fifo_full, combinationally; a frame byte is consumed on each edge with fifo_wr_en=1; state does not advance otherwise.
REQ-024 fifo_data SHALL be SOF_BYTE in SEND_SOF, LEN in SEND_LEN, buffer[rd_idx] in SEND_PAY, CSUM in SEND_CSUM, and 0 otherwise.
REQ-025 SEND_PAY SHALL emit indices 0..LEN-1, then go SEND_CSUM; after the CSUM write go DROP if drop_pending, else IDLE.
REQ-026 DROP SHALL discard accepted bytes until a handshake with s_last=1, then go IDLE and clear drop_pending.
REQ-027 With fifo_full held 0, a LEN-byte frame SHALL occupy exactly LEN+3 consecutive fifo_wr_en cycles starting the cycle after the closing handshake.
REQ-028 fifo_full rising mid-frame SHALL stall the current byte with no loss or duplication; writes resume the cycle fifo_full falls.
REQ-029 CSUM SHALL be accumulated during collection so no extra cycle is needed.

Reset
REQ-030 With rstb=1 at a rising edge: state=IDLE, count=0, rd_idx=0, CSUM accumulator=0, drop_pending=0.
REQ-031 During and after reset: fifo_wr_en=0, fifo_data=0, pkt_done=0, err_trunc=0, busy=0; s_ready=1 from the first cycle after reset.
REQ-032 Reset mid-frame SHALL abandon the frame; no further bytes of it are written; buffer contents need not be cleared.

Verification
REQ-033 Single byte 8'h3C with s_last, fifo_full=0 -> FIFO receives A5, 01, 3C, 3D on 4 consecutive cycles; pkt_done pulses with the 3D write.
REQ-034 Bytes 11,22,33 (last on 33) -> A5, 03, 11, 22, 33, 03; s_ready=0 from the cycle after 33 until back in IDLE.
REQ-035 Frame 01,02 with fifo_full forced high for 3 cycles while in SEND_PAY -> no fifo_wr_en during the stall; output A5, 02, 01, 02, 01 with no gaps other than the stall.
REQ-036 20 bytes 00..13 without last until byte 13, MAX_LEN=16 -> err_trunc pulse; frame A5, 10, 00..0F, CSUM=10; bytes 10..13 accepted and discarded; next packet framed normally.
REQ-037 rstb asserted during SEND_LEN of a 4-byte frame -> fifo_wr_en low from the reset edge onward; busy=0; a subsequent 1-byte packet frames correctly.
REQ-038 Back-to-back packets (s_valid held high) -> no byte lost; second frame begins the cycle after the first CSUM write.
